// File: rtl/poly1305_stream_mac.sv
// Streaming Poly1305 authenticator: 16-byte blocks in, 128-bit tag out.
// The r multiply is iterated MUL_WIDTH bits per cycle into a 256-bit product.
module poly1305_stream_mac #(
  parameter int MUL_WIDTH = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         start,
  input  logic [255:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [3:0]   in_bytes_minus_one,
  input  logic         in_last,
  input  logic         finish,
  output logic         busy,
  output logic         tag_valid,
  output logic [127:0] tag
);

  localparam int C  = 128 / MUL_WIDTH;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam logic [127:0] R_CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam logic [130:0] P_MOD   = {1'b0, 130'h3_ffffffff_ffffffff_ffffffff_fffffffb};

  typedef enum logic [2:0] {IDLE, ACCEPT, MULT, REDUCE, FOLD, SUB, DONE} state_t;

  state_t          state;
  logic [127:0]    r;
  logic [127:0]    s;
  logic [130:0]    h;
  logic [131:0]    a;
  logic [255:0]    prod;
  logic [CW-1:0]   cnt;
  logic            last_blk;

  logic [4:0]              nbytes;
  logic [128:0]            pad;
  logic [127:0]            keep;
  logic [128:0]            m;
  logic [131:0]            a_next;
  logic [MUL_WIDTH-1:0]    r_slice;
  logic [131+MUL_WIDTH:0]  partial;
  logic [255:0]            partial_ext;
  logic [255:0]            prod_next;
  logic [130:0]            hi;
  logic [130:0]            reduced;
  logic [130:0]            folded;
  logic [130:0]            h_mod;
  logic [127:0]            tag_next;
  logic                    unused_h_mod_top;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    nbytes = {1'b0, in_bytes_minus_one} + 5'd1;
    pad    = 129'd1 << {nbytes, 3'b000};
    // For a 16-byte final block pad[127:0] is zero, so keep wraps to all ones.
    keep   = pad[127:0] - 128'd1;
    if (in_last) m = {1'b0, in_data & keep} | pad;
    else         m = {1'b1, in_data};
    a_next = {1'b0, h} + {3'b000, m};

    r_slice     = r[int'(cnt)*MUL_WIDTH +: MUL_WIDTH];
    partial     = {{MUL_WIDTH{1'b0}}, a} * {{132{1'b0}}, r_slice};
    partial_ext = 256'(partial);
    prod_next   = prod + (partial_ext << (MUL_WIDTH * int'(cnt)));

    // 2^130 == 5 (mod p): fold the bits above 130 back in times five.
    hi       = {5'b00000, prod[255:130]};
    reduced  = {1'b0, prod[129:0]} + (hi << 2) + hi;
    folded   = {1'b0, h[129:0]} + (h[130] ? 131'd5 : 131'd0);
    h_mod    = (h >= P_MOD) ? (h - P_MOD) : h;
    tag_next = h_mod[127:0] + s;
  end

  assign unused_h_mod_top = ^h_mod[130:128];

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      r         <= '0;
      s         <= '0;
      h         <= '0;
      a         <= '0;
      prod      <= '0;
      cnt       <= '0;
      last_blk  <= 1'b0;
      tag       <= '0;
      tag_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else if (start) begin
      state     <= ACCEPT;
      r         <= key[127:0] & R_CLAMP;
      s         <= key[255:128];
      h         <= '0;
      cnt       <= '0;
      last_blk  <= 1'b0;
      tag       <= '0;
      tag_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        ACCEPT: begin
          if (in_valid) begin
            a        <= a_next;
            prod     <= '0;
            cnt      <= '0;
            last_blk <= in_last;
            state    <= MULT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else if (finish) begin
            state    <= FOLD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MULT: begin
          prod <= prod_next;
          if (cnt == CW'(C - 1)) state <= REDUCE;
          else                   cnt   <= cnt + CW'(1);
        end
        REDUCE: begin
          h <= reduced;
          if (last_blk) begin
            state <= FOLD;
          end else begin
            state    <= ACCEPT;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        FOLD: begin
          h     <= folded;
          state <= SUB;
        end
        SUB: begin
          tag       <= tag_next;
          tag_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        default: ;
      endcase
    end
  end

endmodule
